// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: word width, bubble encoding and FSM states.
package fetch_stage_pkg;

    localparam int unsigned DEF_WORD_SIZE = 16;
    localparam logic [DEF_WORD_SIZE-1:0] DEF_NOP_INSTR = 16'h0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned             WORD_SIZE = DEF_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]    NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 load,
    input  logic                 bubble,
    input  logic [WORD_SIZE-1:0] d_instr,
    input  logic [WORD_SIZE-1:0] d_pc,
    input  logic [WORD_SIZE-1:0] d_pred_pc,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 valid
);

    logic [WORD_SIZE-1:0] instr_q, pc_q, pred_pc_q;
    logic                 valid_q;

    // Flush wins over load; a bubble keeps the old pc/pred fields.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pred_pc_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush || bubble) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q   <= d_instr;
            pc_q      <= d_pc;
            pred_pc_q <= d_pred_pc;
            valid_q   <= 1'b1;
        end
    end

    assign instr   = instr_q;
    assign pc      = pc_q;
    assign pred_pc = pred_pc_q;
    assign valid   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, request/hold FSM, fetch counter and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = DEF_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pred_next_pc,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] correct_pc,
    output logic [WORD_SIZE-1:0] ifid_instr,
    output logic [WORD_SIZE-1:0] ifid_pc,
    output logic [WORD_SIZE-1:0] ifid_pred_pc,
    output logic                 ifid_valid,
    output logic [WORD_SIZE-1:0] num_fetch
);

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] num_fetch_q, num_fetch_d;
    logic [WORD_SIZE-1:0] hold_instr_q, hold_instr_d;
    logic [WORD_SIZE-1:0] hold_pred_q, hold_pred_d;

    logic                 ld;
    logic                 bubble;
    logic [WORD_SIZE-1:0] ld_instr;
    logic [WORD_SIZE-1:0] ld_pred;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        num_fetch_d  = num_fetch_q;
        hold_instr_d = hold_instr_q;
        hold_pred_d  = hold_pred_q;
        ld           = 1'b0;
        bubble       = 1'b0;
        ld_instr     = i_data;
        ld_pred      = pred_next_pc;

        if (flush) begin
            // Redirect; any data returned this cycle belongs to the wrong path.
            state_d      = S_REQ;
            pc_d         = correct_pc;
            hold_instr_d = '0;
            hold_pred_d  = '0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (i_ready && !stall) begin
                        ld          = 1'b1;
                        pc_d        = pred_next_pc;
                        num_fetch_d = num_fetch_q + WORD_SIZE'(1);
                    end else if (i_ready) begin
                        hold_instr_d = i_data;
                        hold_pred_d  = pred_next_pc;
                        state_d      = S_HOLD;
                    end else if (!stall) begin
                        bubble = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ld          = 1'b1;
                        ld_instr    = hold_instr_q;
                        ld_pred     = hold_pred_q;
                        pc_d        = hold_pred_q;
                        num_fetch_d = num_fetch_q + WORD_SIZE'(1);
                        state_d     = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            num_fetch_q  <= '0;
            hold_instr_q <= '0;
            hold_pred_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            num_fetch_q  <= num_fetch_d;
            hold_instr_q <= hold_instr_d;
            hold_pred_q  <= hold_pred_d;
        end
    end

    ifid_reg #(
        .WORD_SIZE (WORD_SIZE),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .load      (ld),
        .bubble    (bubble),
        .d_instr   (ld_instr),
        .d_pc      (pc_q),
        .d_pred_pc (ld_pred),
        .instr     (ifid_instr),
        .pc        (ifid_pc),
        .pred_pc   (ifid_pred_pc),
        .valid     (ifid_valid)
    );

    assign pc        = pc_q;
    assign i_address = pc_q;
    assign i_readM   = (state_q == S_REQ) && reset_n;
    assign num_fetch = num_fetch_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pred_next_pc;
    logic [15:0] pc;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        stall;
    logic        flush;
    logic [15:0] correct_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pred_pc;
    logic        ifid_valid;
    logic [15:0] num_fetch;

    int vectors = 0;
    int miscompares = 0;

    // Model of the architecturally visible state.
    logic [15:0] m_pc, m_instr, m_ipc, m_ipred, m_cnt, m_hinstr, m_hpred;
    logic        m_valid, m_held;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pred_next_pc (pred_next_pc),
        .pc           (pc),
        .i_readM      (i_readM),
        .i_address    (i_address),
        .i_data       (i_data),
        .i_ready      (i_ready),
        .stall        (stall),
        .flush        (flush),
        .correct_pc   (correct_pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pred_pc (ifid_pred_pc),
        .ifid_valid   (ifid_valid),
        .num_fetch    (num_fetch)
    );

    function automatic logic [97:0] obs();
        return {pc, ifid_instr, ifid_pc, ifid_pred_pc, ifid_valid, num_fetch, i_readM, i_address};
    endfunction

    function automatic logic [97:0] expv();
        logic rd;
        rd = reset_n && !m_held;
        return {m_pc, m_instr, m_ipc, m_ipred, m_valid, m_cnt, rd, m_pc};
    endfunction

    // One clock edge: model applies the rules to the inputs present at the edge.
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            m_pc = 16'h0000; m_held = 1'b0; m_hinstr = '0; m_hpred = '0;
            m_instr = 16'h0000; m_ipc = '0; m_ipred = '0; m_valid = 1'b0; m_cnt = '0;
        end else if (flush) begin
            m_pc = correct_pc; m_held = 1'b0; m_hinstr = '0; m_hpred = '0;
            m_instr = 16'h0000; m_valid = 1'b0;
        end else if (m_held) begin
            if (!stall) begin
                m_instr = m_hinstr; m_ipc = m_pc; m_ipred = m_hpred; m_valid = 1'b1;
                m_pc = m_hpred; m_cnt = m_cnt + 16'd1; m_held = 1'b0;
            end
        end else if (i_ready && !stall) begin
            m_instr = i_data; m_ipc = m_pc; m_ipred = pred_next_pc; m_valid = 1'b1;
            m_pc = pred_next_pc; m_cnt = m_cnt + 16'd1;
        end else if (i_ready) begin
            m_held = 1'b1; m_hinstr = i_data; m_hpred = pred_next_pc;
        end else if (!stall) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic fl, input logic [15:0] pred);
        i_ready      = rdy;
        stall        = stl;
        flush        = fl;
        pred_next_pc = pred;
        i_data       = 16'($urandom);
        correct_pc   = 16'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h1234);
        step();
        step();
        vectors++;
        if (obs() !== expv()) begin
            $display("FAIL reset_state: got %h want %h", obs(), expv());
            miscompares++;
        end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (i_readM !== 1'b1 || i_address !== 16'h0000) begin
            $display("FAIL reset_release: readM=%b addr=%h want 1/0000", i_readM, i_address);
            miscompares++;
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, m_pc + 16'd1);
            step();
            vectors++;
            if (ifid_pc !== 16'(i) || ifid_valid !== 1'b1 || obs() !== expv()) begin
                $display("FAIL seq_fetch%0d: ifid_pc=%h got %h want %h", i, ifid_pc, obs(), expv());
                miscompares++;
            end
        end
        vectors++;
        if (num_fetch !== 16'd4) begin
            $display("FAIL seq_count: got %0d want 4", num_fetch);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        logic [15:0] frozen;
        drive(1'b1, 1'b0, 1'b0, 16'h0005);
        step();
        frozen = ifid_pc;
        drive(1'b1, 1'b1, 1'b0, 16'h0123);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (i_readM !== 1'b0 || ifid_pc !== 16'h0004 || obs() !== expv()) begin
                $display("FAIL stall_hold%0d: got %h want %h (frozen %h)", i, obs(), expv(), frozen);
                miscompares++;
            end
            drive(1'b1, 1'b1, 1'b0, 16'($urandom));
        end
        drive(1'b1, 1'b0, 1'b0, 16'($urandom));
        step();
        vectors++;
        if (ifid_pc !== 16'h0005 || pc !== 16'h0123 || ifid_pred_pc !== 16'h0123
            || obs() !== expv()) begin
            $display("FAIL stall_release: got %h want %h", obs(), expv());
            miscompares++;
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b1, 16'h0999);
        correct_pc = 16'h0040;
        step();
        vectors++;
        if (pc !== 16'h0040 || ifid_valid !== 1'b0 || i_readM !== 1'b1 || obs() !== expv()) begin
            $display("FAIL flush_req: got %h want %h", obs(), expv());
            miscompares++;
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0041);
        step();
        vectors++;
        if (ifid_pc !== 16'h0040 || obs() !== expv()) begin
            $display("FAIL flush_refetch: got %h want %h", obs(), expv());
            miscompares++;
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0777);
        step();
        drive(1'b0, 1'b1, 1'b1, 16'h0777);
        correct_pc = 16'h0080;
        step();
        vectors++;
        if (pc !== 16'h0080 || i_readM !== 1'b1 || obs() !== expv()) begin
            $display("FAIL flush_hold: got %h want %h", obs(), expv());
            miscompares++;
        end
    endtask

    task automatic test_bubbles();
        logic [15:0] pc0;
        drive(1'b1, 1'b0, 1'b0, 16'h00A0);
        step();
        pc0 = pc;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'($urandom));
            step();
            vectors++;
            if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || pc !== 16'h00A0
                || obs() !== expv()) begin
                $display("FAIL bubble%0d: got %h want %h (pc before %h)", i, obs(), expv(), pc0);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1'b1, 1'b1, 1'b0, 16'h0BAD);
        step();
        reset_n = 1'b0;
        step();
        vectors++;
        if (pc !== 16'h0000 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000
            || ifid_pc !== 16'h0000 || ifid_pred_pc !== 16'h0000 || num_fetch !== 16'h0000
            || obs() !== expv()) begin
            $display("FAIL reset_in_hold: got %h want %h", obs(), expv());
            miscompares++;
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        vectors++;
        if (i_readM !== 1'b1 || i_address !== 16'h0000) begin
            $display("FAIL reset_hold_release: readM=%b addr=%h", i_readM, i_address);
            miscompares++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 9) == 0), 16'($urandom));
            step();
            vectors++;
            if (obs() !== expv()) begin
                $display("FAIL random%0d: got %h want %h", i, obs(), expv());
                miscompares++;
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_wrap();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, 1'b0, m_pc + 16'd1);
            step();
        end
        vectors++;
        if (num_fetch !== 16'hFFFF || obs() !== expv()) begin
            $display("FAIL count_preload: got %h want num_fetch ffff", num_fetch);
            miscompares++;
        end
        drive(1'b1, 1'b0, 1'b0, m_pc + 16'd1);
        step();
        vectors++;
        if (num_fetch !== 16'h0000 || obs() !== expv()) begin
            $display("FAIL count_wrap: got %h want 0000", num_fetch);
            miscompares++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        m_held = 1'b0;
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_bubbles();
        test_reset_in_hold();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
